// File: rtl/icache_refill_axi.sv
// Instruction-cache line refill bridge: one aligned AXI4 INCR read burst per
// refill request, returned to the cache as indexed 64-bit beats.
module icache_refill_axi #(
    parameter int         LINE_BYTES = 64,
    parameter logic [3:0] AXI_ID     = 4'd0,
    localparam int        BEATS      = LINE_BYTES / 8,
    localparam int        BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic [63:0]   req_addr_i,
    output logic          beat_valid_o,
    output logic [63:0]   beat_data_o,
    output logic [BW-1:0] beat_idx_o,
    output logic          done_o,
    output logic          err_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    output logic [63:0]   araddr_o,
    output logic [7:0]    arlen_o,
    output logic [2:0]    arsize_o,
    output logic [1:0]    arburst_o,
    output logic [3:0]    arid_o,
    input  logic          rvalid_i,
    output logic          rready_o,
    input  logic [63:0]   rdata_i,
    input  logic [1:0]    rresp_i,
    input  logic          rlast_i
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] cnt;
    logic          err_flag;
    logic          ending;
    logic          r_hs;
    logic          last_beat;
    logic          beat_err;
    logic          beat_end;

    // The terminating beat closes R immediately, but DONE waits one cycle so
    // done_o trails the final beat_valid_o.
    assign arvalid_o = (state == ADDR);
    assign rready_o  = (state == DATA) && !ending;
    assign done_o    = (state == DONE);
    assign err_o     = (state == DONE) && err_flag;

    assign r_hs      = rvalid_i && rready_o;
    assign last_beat = (cnt == BW'(BEATS - 1));
    assign beat_err  = (rresp_i != 2'b00) || (rlast_i != last_beat);
    assign beat_end  = rlast_i || last_beat;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i)     state_nxt = ADDR;
            ADDR:    if (arready_i) state_nxt = DATA;
            DATA:    if (ending)    state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            err_flag     <= 1'b0;
            ending       <= 1'b0;
            beat_valid_o <= 1'b0;
            beat_data_o  <= '0;
            beat_idx_o   <= '0;
            araddr_o     <= '0;
            arlen_o      <= '0;
            arsize_o     <= '0;
            arburst_o    <= '0;
            arid_o       <= '0;
        end else begin
            state        <= state_nxt;
            beat_valid_o <= r_hs;
            if (state == IDLE && req_i) begin
                araddr_o  <= req_addr_i & ~64'(LINE_BYTES - 1);
                arlen_o   <= 8'(BEATS - 1);
                arsize_o  <= 3'b011;
                arburst_o <= 2'b01;
                arid_o    <= AXI_ID;
                cnt       <= '0;
                err_flag  <= 1'b0;
                ending    <= 1'b0;
            end
            if (r_hs) begin
                beat_data_o <= rdata_i;
                beat_idx_o  <= cnt;
                cnt         <= last_beat ? '0 : cnt + 1'b1;
                if (beat_err) err_flag <= 1'b1;
                if (beat_end) ending   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Bench for icache_refill_axi: randomized AXI R/AR stimulus against a
// line-level reference model of which beats are delivered and the error result.
module tb_icache_refill_axi;
    localparam int LB = 64;
    localparam int NB = LB / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic [63:0] req_addr_i = '0;
    logic        beat_valid_o;
    logic [63:0] beat_data_o;
    logic [2:0]  beat_idx_o;
    logic        done_o;
    logic        err_o;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [63:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [3:0]  arid_o;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic [63:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rlast_i = 1'b0;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    logic [63:0] tx_data[16];
    logic [1:0]  tx_resp[16];
    logic        tx_last[16];

    int          obs_idx[$];
    logic [63:0] obs_data[$];
    longint      obs_cyc[$];
    int          done_cnt;
    longint      done_cyc;
    logic        done_err;

    logic [63:0] ar_addr_obs;
    logic [7:0]  ar_len_obs;
    logic [2:0]  ar_size_obs;
    logic [1:0]  ar_burst_obs;
    logic [3:0]  ar_id_obs;
    int          ar_cycles;
    bit          ar_unstable;
    int          ar_extra;
    bit          tmo;
    bit          post_ar;

    icache_refill_axi #(.LINE_BYTES(LB), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_addr_i(req_addr_i),
        .beat_valid_o(beat_valid_o), .beat_data_o(beat_data_o), .beat_idx_o(beat_idx_o),
        .done_o(done_o), .err_o(err_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (beat_valid_o) begin
            obs_idx.push_back(int'(beat_idx_o));
            obs_data.push_back(beat_data_o);
            obs_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_tx(input bit dead);
        for (int i = 0; i < 16; i++) begin
            tx_data[i] = dead ? (64'hDEAD_0000 + 64'(i)) : {$urandom, $urandom};
            tx_resp[i] = 2'b00;
            tx_last[i] = (i == NB - 1);
        end
    endtask

    // Line-level rule: beats go out in order until the first one carrying
    // RLAST or the line's final slot; error if any RRESP!=OKAY or RLAST misplaced.
    task automatic model(input int nsend, output int en, output bit ee);
        en = 0;
        ee = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            en++;
            if (tx_resp[i] != 2'b00) ee = 1'b1;
            if (tx_last[i] != (i == NB - 1)) ee = 1'b1;
            if (tx_last[i] || i == NB - 1) break;
        end
    endtask

    task automatic drive_burst(input logic [63:0] addr, input int ar_wait,
                               input int gap_mode, input int nsend, input bit jitter);
        int guard;
        int i;
        int g;
        bit hs;
        bit seen;
        bit v;
        obs_idx.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cnt = 0;
        tmo = 1'b0;
        ar_cycles = 0;
        ar_unstable = 1'b0;
        ar_extra = 0;
        post_ar = 1'b0;
        @(negedge clk);
        req_i = 1'b1;
        req_addr_i = addr;
        arready_i = (ar_wait == 0);
        guard = 0;
        hs = 1'b0;
        while (!hs && guard < 50) begin
            @(negedge clk);
            guard++;
            if (jitter) req_addr_i = {$urandom, $urandom};
            if (arvalid_o) begin
                if (ar_cycles == 0) begin
                    ar_addr_obs  = araddr_o;
                    ar_len_obs   = arlen_o;
                    ar_size_obs  = arsize_o;
                    ar_burst_obs = arburst_o;
                    ar_id_obs    = arid_o;
                end else if (araddr_o !== ar_addr_obs) begin
                    ar_unstable = 1'b1;
                end
                ar_cycles++;
                arready_i = (ar_cycles > ar_wait);
                hs = arready_i;
            end
        end
        if (!hs) tmo = 1'b1;
        i = 0;
        g = 0;
        seen = 1'b0;
        guard = 0;
        while (hs && !seen && guard < 200) begin
            @(negedge clk);
            guard++;
            arready_i = 1'b0;
            if (arvalid_o) ar_extra++;
            if (done_o) begin
                req_i = 1'b0;
                rvalid_i = 1'b0;
                seen = 1'b1;
            end else if (i < nsend && rready_o) begin
                v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (g % 3 == 0) : 1'($urandom_range(0, 1));
                g++;
                rvalid_i = v;
                rdata_i  = v ? tx_data[i] : {$urandom, $urandom};
                rresp_i  = v ? tx_resp[i] : 2'($urandom);
                rlast_i  = v ? tx_last[i] : 1'($urandom);
                if (v) i++;
            end else begin
                rvalid_i = 1'b0;
                rlast_i = 1'b0;
            end
        end
        if (!seen) tmo = 1'b1;
        req_i = 1'b0;
        rvalid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (arvalid_o) post_ar = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({arvalid_o, rready_o, beat_valid_o, done_o, err_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {arvalid_o, rready_o, beat_valid_o, done_o, err_o});
        end
        checks++;
        if (araddr_o !== 64'd0 || beat_data_o !== 64'd0 || beat_idx_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%0d exp=0/0/0", araddr_o, beat_data_o, beat_idx_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({arvalid_o, rready_o, done_o} !== 3'b0) begin
            failures++;
            $display("FAIL idle_no_req got=%b exp=000", {arvalid_o, rready_o, done_o});
        end
    endtask

    task automatic test_basic();
        int en;
        bit ee;
        fill_tx(1'b1);
        drive_burst(64'h8000_0034, 0, 0, NB, 1'b0);
        model(NB, en, ee);
        checks++;
        if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++;
        if (ar_addr_obs !== 64'h8000_0000) begin
            failures++; $display("FAIL basic_araddr got=%h exp=80000000", ar_addr_obs);
        end
        checks++;
        if ({ar_len_obs, ar_size_obs, ar_burst_obs, ar_id_obs} !== {8'd7, 3'b011, 2'b01, 4'd0}) begin
            failures++;
            $display("FAIL basic_arfields got=%0d/%0d/%0d/%0d exp=7/3/1/0", ar_len_obs, ar_size_obs, ar_burst_obs, ar_id_obs);
        end
        checks++;
        if (obs_idx.size() != en || en != NB) begin
            failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_idx.size(), NB);
        end
        for (int k = 0; k < obs_idx.size() && k < NB; k++) begin
            checks++;
            if (obs_idx[k] != k || obs_data[k] !== 64'hDEAD_0000 + 64'(k) || obs_cyc[k] != obs_cyc[0] + k) begin
                failures++;
                $display("FAIL basic_beat%0d got=%0d/%h exp=%0d/%h", k, obs_idx[k], obs_data[k], k, 64'hDEAD_0000 + 64'(k));
            end
        end
        checks++;
        if (done_cnt != 1 || done_err !== 1'b0 || obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size() - 1] + 1) begin
            failures++; $display("FAIL basic_done got=cnt%0d err%b exp=cnt1 err0 one cycle after last beat", done_cnt, done_err);
        end
        checks++;
        if (post_ar !== 1'b0) begin failures++; $display("FAIL basic_restart got=1 exp=0"); end
    endtask

    task automatic test_ar_stall();
        logic [63:0] a;
        int en;
        bit ee;
        fill_tx(1'b0);
        a = {$urandom, $urandom};
        drive_burst(a, 5, 0, NB, 1'b1);
        model(NB, en, ee);
        checks++;
        if (ar_cycles != 6 || ar_unstable !== 1'b0 || ar_extra != 0 || tmo !== 1'b0) begin
            failures++;
            $display("FAIL stall_ar got=cycles%0d unstable%b extra%0d exp=cycles6 unstable0 extra0", ar_cycles, ar_unstable, ar_extra);
        end
        checks++;
        if (ar_addr_obs !== (a & ~64'(LB - 1))) begin
            failures++; $display("FAIL stall_araddr got=%h exp=%h", ar_addr_obs, a & ~64'(LB - 1));
        end
        checks++;
        if (obs_idx.size() != en || done_cnt != 1 || done_err !== ee) begin
            failures++; $display("FAIL stall_burst got=%0d beats err%b exp=%0d beats err%b", obs_idx.size(), done_err, en, ee);
        end
    endtask

    task automatic test_rvalid_gaps();
        int en;
        bit ee;
        fill_tx(1'b0);
        drive_burst({$urandom, $urandom}, 1, 1, NB, 1'b0);
        model(NB, en, ee);
        checks++;
        if (obs_idx.size() != en || tmo !== 1'b0) begin
            failures++; $display("FAIL gaps_count got=%0d exp=%0d", obs_idx.size(), en);
        end
        for (int k = 0; k < obs_idx.size() && k < en; k++) begin
            checks++;
            if (obs_idx[k] != k || obs_data[k] !== tx_data[k] || (k > 0 && obs_cyc[k] != obs_cyc[k - 1] + 3)) begin
                failures++; $display("FAIL gaps_beat%0d got=%0d/%h exp=%0d/%h", k, obs_idx[k], obs_data[k], k, tx_data[k]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_err !== 1'b0) begin
            failures++; $display("FAIL gaps_done got=cnt%0d err%b exp=cnt1 err0", done_cnt, done_err);
        end
    endtask

    task automatic test_r_errors();
        int en;
        bit ee;
        int ex_n[3] = '{8, 6, 8};
        for (int c = 0; c < 3; c++) begin
            fill_tx(1'b0);
            if (c == 0) tx_resp[3] = 2'b10;
            if (c == 1) tx_last[5] = 1'b1;
            if (c == 2) tx_last[NB - 1] = 1'b0;
            drive_burst({$urandom, $urandom}, c, 0, NB, 1'b0);
            model(NB, en, ee);
            checks++;
            if (obs_idx.size() != ex_n[c] || en != ex_n[c] || tmo !== 1'b0) begin
                failures++; $display("FAIL rerr%0d_count got=%0d exp=%0d", c, obs_idx.size(), ex_n[c]);
            end
            for (int k = 0; k < obs_idx.size() && k < en; k++) begin
                checks++;
                if (obs_idx[k] != k || obs_data[k] !== tx_data[k]) begin
                    failures++; $display("FAIL rerr%0d_beat%0d got=%0d/%h exp=%0d/%h", c, k, obs_idx[k], obs_data[k], k, tx_data[k]);
                end
            end
            checks++;
            if (done_cnt != 1 || done_err !== 1'b1 || ee !== 1'b1 || obs_cyc.size() == 0 ||
                done_cyc != obs_cyc[obs_cyc.size() - 1] + 1 || post_ar !== 1'b0) begin
                failures++; $display("FAIL rerr%0d_done got=cnt%0d err%b exp=cnt1 err1", c, done_cnt, done_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int en;
        bit ee;
        fill_tx(1'b0);
        @(negedge clk);
        req_i = 1'b1;
        req_addr_i = {$urandom, $urandom};
        arready_i = 1'b1;
        guard = 0;
        while (!arvalid_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            arready_i = 1'b0;
            rvalid_i = 1'b1;
            rdata_i = tx_data[k];
            rresp_i = 2'b00;
            rlast_i = 1'b0;
        end
        checks++;
        if (beat_valid_o !== 1'b1 || beat_idx_o !== 3'd3 || rready_o !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre got=v%b idx%0d exp=v1 idx3", beat_valid_o, beat_idx_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({arvalid_o, rready_o, beat_valid_o, done_o, err_o} !== 5'b0 || araddr_o !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_async got=%b addr=%h exp=00000 addr=0", {arvalid_o, rready_o, beat_valid_o, done_o, err_o}, araddr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        req_i = 1'b0;
        rvalid_i = 1'b0;
        rlast_i = 1'b0;
        fill_tx(1'b0);
        drive_burst({$urandom, $urandom}, 0, 2, NB, 1'b0);
        model(NB, en, ee);
        checks++;
        if (obs_idx.size() != en || done_cnt != 1 || done_err !== 1'b0 || tmo !== 1'b0) begin
            failures++; $display("FAIL rstmid_after got=%0d beats err%b exp=%0d beats err0", obs_idx.size(), done_err, en);
        end
        for (int k = 0; k < obs_idx.size() && k < en; k++) begin
            checks++;
            if (obs_idx[k] != k || obs_data[k] !== tx_data[k]) begin
                failures++; $display("FAIL rstmid_beat%0d got=%0d/%h exp=%0d/%h", k, obs_idx[k], obs_data[k], k, tx_data[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        int en;
        bit ee;
        for (int n = 0; n < 8; n++) begin
            fill_tx(1'b0);
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 9) == 0) tx_resp[i] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) tx_last[$urandom_range(0, NB - 2)] = 1'b1;
            if ($urandom_range(0, 4) == 0) tx_last[NB - 1] = 1'b0;
            a = {$urandom, $urandom};
            drive_burst(a, $urandom_range(0, 3), 2, NB, 1'b1);
            model(NB, en, ee);
            checks++;
            if (ar_addr_obs !== (a & ~64'(LB - 1)) || ar_unstable !== 1'b0 || ar_extra != 0 || tmo !== 1'b0) begin
                failures++; $display("FAIL rand%0d_ar got=%h exp=%h", n, ar_addr_obs, a & ~64'(LB - 1));
            end
            checks++;
            if (obs_idx.size() != en) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, obs_idx.size(), en);
            end
            for (int k = 0; k < obs_idx.size() && k < en; k++) begin
                checks++;
                if (obs_idx[k] != k % NB || obs_data[k] !== tx_data[k]) begin
                    failures++; $display("FAIL rand%0d_beat%0d got=%0d/%h exp=%0d/%h", n, k, obs_idx[k], obs_data[k], k % NB, tx_data[k]);
                end
            end
            checks++;
            if (done_cnt != 1 || done_err !== ee || post_ar !== 1'b0) begin
                failures++; $display("FAIL rand%0d_done got=cnt%0d err%b exp=cnt1 err%b", n, done_cnt, done_err, ee);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_ar_stall();
        test_rvalid_gaps();
        test_r_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
